// File: rtl/buffer_state_engine_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// buffer_state_engine_pkg : shared sizes, packet fields and display geometry
// Revision: 1.0
// ---------------------------------------------------------------------------
package buffer_state_engine_pkg;
  localparam int NBUF   = 4;
  localparam int DEPTH  = 6;
  localparam int DW     = 4;
  localparam int CW     = 8;
  localparam int PTR_W  = 3;
  localparam int BID_HI = 3;
  localparam int BID_LO = 2;

  // Box geometry used by the VGA buffer-status display stage.
  localparam int BOX_W   = 24;
  localparam int BOX_H   = 16;
  localparam int BOX_GAP = 4;

  typedef logic [DW-1:0]    pkt_t;
  typedef logic [PTR_W-1:0] cnt_t;

  function automatic logic [1:0] buf_id(input pkt_t p);
    return p[BID_HI:BID_LO];
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction
endpackage
`default_nettype wire

// File: rtl/buffer_state_engine_pkt_ring.sv
`default_nettype none
// ---------------------------------------------------------------------------
// buffer_state_engine_pkt_ring : DEPTH-slot circular packet store
// Revision: 1.0
// ---------------------------------------------------------------------------
module buffer_state_engine_pkt_ring
  import buffer_state_engine_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  pkt_t push_pkt,
  input  logic pop,
  output pkt_t head_pkt,
  output cnt_t count,
  output logic drop,
  input  cnt_t rd_idx,
  output pkt_t rd_pkt
);
  localparam cnt_t           DEPTH_C = cnt_t'(DEPTH);
  localparam logic [PTR_W:0] DEPTH_W = (PTR_W+1)'(DEPTH);

  pkt_t mem [DEPTH];
  cnt_t head;
  cnt_t tail;
  logic full;
  logic do_pop;
  logic adv_head;
  logic [PTR_W:0] sum;
  cnt_t slot;

  function automatic cnt_t wrap_inc(input cnt_t p);
    return (p == DEPTH_C - cnt_t'(1)) ? '0 : p + cnt_t'(1);
  endfunction

  assign full     = (count == DEPTH_C);
  assign do_pop   = pop && (count != '0);
  // Overwrite only when nothing was popped this cycle; pop-then-push frees a slot.
  assign drop     = push && full && !do_pop;
  assign adv_head = do_pop || drop;
  assign head_pkt = mem[head];

  assign sum    = {1'b0, head} + {1'b0, rd_idx};
  assign slot   = (sum >= DEPTH_W) ? cnt_t'(sum - DEPTH_W) : sum[PTR_W-1:0];
  assign rd_pkt = (rd_idx < DEPTH_C) ? mem[slot] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (adv_head) head <= wrap_inc(head);
      if (push)     tail <= wrap_inc(tail);
      if (push && !adv_head)
        count <= count + cnt_t'(1);
      else if (!push && do_pop)
        count <= count - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[tail] <= push_pkt;
  end
endmodule
`default_nettype wire

// File: rtl/buffer_state_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// buffer_state_engine : four packet rings, fullest-first reader, counters
// Revision: 1.0
// ---------------------------------------------------------------------------
module buffer_state_engine
  import buffer_state_engine_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_pkt,
  input  logic            rd_req,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_pkt,
  output logic [DW-1:0]   last_in,
  output logic [4*3-1:0]  occ,
  output logic [CW-1:0]   trans_cnt,
  output logic [CW-1:0]   recv_cnt,
  output logic [CW-1:0]   drop_cnt,
  input  logic [1:0]      q_buf,
  input  logic [2:0]      q_slot,
  output logic            q_valid,
  output logic [DW-1:0]   q_pkt
);
  cnt_t cnt   [NBUF];
  pkt_t head  [NBUF];
  pkt_t slot  [NBUF];
  logic [NBUF-1:0] push;
  logic [NBUF-1:0] pop;
  logic [NBUF-1:0] drop;

  logic [1:0] sel_lo, sel_hi, sel;
  cnt_t       max_lo, max_hi, max_all;
  logic       any_data;
  logic       do_read;
  logic       q_hit;

  // Compare tree: pairs, then pair winners, then non-empty check. Ties keep the lower index.
  assign sel_lo   = (cnt[0] >= cnt[1]) ? 2'd0 : 2'd1;
  assign max_lo   = (cnt[0] >= cnt[1]) ? cnt[0] : cnt[1];
  assign sel_hi   = (cnt[2] >= cnt[3]) ? 2'd2 : 2'd3;
  assign max_hi   = (cnt[2] >= cnt[3]) ? cnt[2] : cnt[3];
  assign sel      = (max_lo >= max_hi) ? sel_lo : sel_hi;
  assign max_all  = (max_lo >= max_hi) ? max_lo : max_hi;
  assign any_data = (max_all != '0);
  assign do_read  = rd_req && any_data;

  generate
    for (genvar b = 0; b < NBUF; b++) begin : g_ring
      assign push[b] = in_valid && (buf_id(in_pkt) == 2'(b));
      assign pop[b]  = do_read && (sel == 2'(b));
      assign occ[3*b +: 3] = cnt[b];

      buffer_state_engine_pkt_ring u_ring (
        .clk      (clk),
        .reset    (reset),
        .push     (push[b]),
        .push_pkt (in_pkt),
        .pop      (pop[b]),
        .head_pkt (head[b]),
        .count    (cnt[b]),
        .drop     (drop[b]),
        .rd_idx   (q_slot),
        .rd_pkt   (slot[b])
      );
    end
  endgenerate

  assign q_hit = (q_slot < cnt[q_buf]);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_pkt    <= '0;
      last_in   <= '0;
      trans_cnt <= '0;
      recv_cnt  <= '0;
      drop_cnt  <= '0;
      q_valid   <= 1'b0;
      q_pkt     <= '0;
    end else begin
      rd_valid <= do_read;
      if (do_read) begin
        rd_pkt    <= head[sel];
        trans_cnt <= sat_inc(trans_cnt);
      end
      if (in_valid) begin
        last_in  <= in_pkt;
        recv_cnt <= sat_inc(recv_cnt);
      end
      if (|drop) drop_cnt <= sat_inc(drop_cnt);
      q_valid <= q_hit;
      q_pkt   <= q_hit ? slot[q_buf] : '0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_buffer_state_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_buffer_state_engine : queue-model scoreboard with directed and random traffic
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_buffer_state_engine;
  logic        clk = 1'b0;
  logic        reset, in_valid, rd_req;
  logic [3:0]  in_pkt, rd_pkt, last_in, q_pkt;
  logic [11:0] occ;
  logic [7:0]  trans_cnt, recv_cnt, drop_cnt;
  logic [1:0]  q_buf;
  logic [2:0]  q_slot;
  logic        rd_valid, q_valid;

  always #10 clk = ~clk;

  buffer_state_engine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pkt(in_pkt), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_pkt(rd_pkt), .last_in(last_in), .occ(occ),
    .trans_cnt(trans_cnt), .recv_cnt(recv_cnt), .drop_cnt(drop_cnt),
    .q_buf(q_buf), .q_slot(q_slot), .q_valid(q_valid), .q_pkt(q_pkt)
  );

  typedef struct {
    logic        rdv;
    logic [3:0]  rdp;
    logic [3:0]  li;
    logic [11:0] occ;
    logic [7:0]  tc, rc, dc;
    logic        qv;
    logic [3:0]  qp;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] rdq[$];
  logic [3:0] mq[4][$];
  logic [3:0] m_rdp, m_li;
  int         m_tc, m_rc, m_dc;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Reference: each buffer is a plain queue of at most 6 packets.
  task automatic model_step(input bit rst, input bit iv, input logic [3:0] p, input bit rr,
                            input int qb, input int qs, output exp_t e, output bit popped);
    popped = 0;
    e.rdv = 0;
    e.qv  = 0;
    e.qp  = '0;
    if (rst) begin
      for (int b = 0; b < 4; b++) mq[b].delete();
      m_rdp = '0; m_li = '0; m_tc = 0; m_rc = 0; m_dc = 0;
    end else begin
      if (qs < mq[qb].size()) begin
        e.qv = 1;
        e.qp = mq[qb][qs];
      end
      if (rr) begin
        int best = -1;
        int bsz  = 0;
        for (int b = 0; b < 4; b++)
          if (mq[b].size() > bsz) begin
            bsz  = mq[b].size();
            best = b;
          end
        if (best >= 0) begin
          m_rdp  = mq[best].pop_front();
          m_tc   = sat(m_tc);
          e.rdv  = 1;
          popped = 1;
        end
      end
      if (iv) begin
        int b = int'(p[3:2]);
        m_rc = sat(m_rc);
        m_li = p;
        if (mq[b].size() == 6) begin
          void'(mq[b].pop_front());
          m_dc = sat(m_dc);
        end
        mq[b].push_back(p);
      end
    end
    e.rdp = m_rdp;
    e.li  = m_li;
    e.tc  = 8'(m_tc);
    e.rc  = 8'(m_rc);
    e.dc  = 8'(m_dc);
    for (int b = 0; b < 4; b++) e.occ[3*b +: 3] = 3'(mq[b].size());
  endtask

  task automatic step(input bit rst, input bit iv, input logic [3:0] p, input bit rr,
                      input logic [1:0] qb, input logic [2:0] qs);
    exp_t e;
    bit   popped;
    reset = rst; in_valid = iv; in_pkt = p; rd_req = rr; q_buf = qb; q_slot = qs;
    model_step(rst, iv, p, rr, int'(qb), int'(qs), e, popped);
    @(posedge clk);
    expq.push_back(e);
    if (popped) rdq.push_back(e.rdp);
    #1;
  endtask

  task automatic push_pkt(input logic [3:0] p);
    step(0, 1, p, 0, 2'd0, 3'd0);
  endtask

  // Monitor: full-state comparison every cycle; read packets matched against the read queue.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("rd_valid",  32'(rd_valid),  32'(e.rdv));
      chk("rd_pkt",    32'(rd_pkt),    32'(e.rdp));
      chk("last_in",   32'(last_in),   32'(e.li));
      chk("occ",       32'(occ),       32'(e.occ));
      chk("trans_cnt", 32'(trans_cnt), 32'(e.tc));
      chk("recv_cnt",  32'(recv_cnt),  32'(e.rc));
      chk("drop_cnt",  32'(drop_cnt),  32'(e.dc));
      chk("q_valid",   32'(q_valid),   32'(e.qv));
      chk("q_pkt",     32'(q_pkt),     32'(e.qp));
      if (rd_valid) begin
        if (rdq.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'(0));
        else                 chk("rd_stream", 32'(rd_pkt), 32'(rdq.pop_front()));
      end
    end
  end

  initial begin
    reset = 1; in_valid = 0; in_pkt = '0; rd_req = 0; q_buf = '0; q_slot = '0;
    step(1, 0, 4'h0, 0, 2'd0, 3'd0);
    step(1, 0, 4'h0, 0, 2'd0, 3'd0);
    chk("reset_occ", 32'(occ), 32'(0));

    // Read with everything empty.
    step(0, 0, 4'h0, 1, 2'd0, 3'd0);
    chk("empty_rd_valid", 32'(rd_valid), 32'(0));
    chk("empty_trans", 32'(trans_cnt), 32'(0));
    chk("empty_rd_pkt", 32'(rd_pkt), 32'(0));

    // Three packets into buffer 2, then query slot 0 and an unoccupied slot.
    push_pkt(4'h9); push_pkt(4'hA); push_pkt(4'hB);
    chk("occ2_three", 32'(occ[8:6]), 32'(3));
    step(0, 0, 4'h0, 0, 2'd2, 3'd0);
    chk("q20_valid", 32'(q_valid), 32'(1));
    chk("q20_pkt", 32'(q_pkt), 32'(4'h9));
    step(0, 0, 4'h0, 0, 2'd2, 3'd3);
    chk("q23_valid", 32'(q_valid), 32'(0));
    chk("q23_pkt", 32'(q_pkt), 32'(0));

    // Overfill buffer 0 by one.
    step(1, 0, 4'h0, 0, 2'd0, 3'd0);
    for (int i = 0; i < 7; i++) push_pkt(4'(i % 4));
    chk("occ0_full", 32'(occ[2:0]), 32'(6));
    chk("drop_one", 32'(drop_cnt), 32'(1));
    step(0, 0, 4'h0, 0, 2'd0, 3'd0);
    chk("q00_second", 32'(q_pkt), 32'(4'h1));
    step(0, 0, 4'h0, 0, 2'd0, 3'd6);
    chk("q_slot_oob", 32'(q_valid), 32'(0));

    // occ = {2,4,4,1}: tie between buffers 1 and 2 goes to buffer 1.
    step(1, 0, 4'h0, 0, 2'd0, 3'd0);
    push_pkt(4'h0); push_pkt(4'h1);
    push_pkt(4'h4); push_pkt(4'h5); push_pkt(4'h6); push_pkt(4'h7);
    push_pkt(4'h8); push_pkt(4'h9); push_pkt(4'hA); push_pkt(4'hB);
    push_pkt(4'hC);
    step(0, 0, 4'h0, 1, 2'd0, 3'd0);
    chk("tie_rd_pkt", 32'(rd_pkt), 32'(4'h4));
    chk("tie_trans", 32'(trans_cnt), 32'(1));
    chk("tie_occ1", 32'(occ[5:3]), 32'(3));

    // Full buffer 3 read and written in the same cycle: no drop.
    step(1, 0, 4'h0, 0, 2'd0, 3'd0);
    push_pkt(4'hC); push_pkt(4'hD); push_pkt(4'hE);
    push_pkt(4'hF); push_pkt(4'hC); push_pkt(4'hD);
    step(0, 1, 4'hF, 1, 2'd3, 3'd0);
    chk("rw_rd_pkt", 32'(rd_pkt), 32'(4'hC));
    chk("rw_occ3", 32'(occ[11:9]), 32'(6));
    chk("rw_drop", 32'(drop_cnt), 32'(0));
    step(0, 0, 4'h0, 0, 2'd3, 3'd5);
    chk("rw_tail", 32'(q_pkt), 32'(4'hF));

    // Receive counter saturation, then reset coincident with a push.
    step(1, 0, 4'h0, 0, 2'd0, 3'd0);
    for (int i = 0; i < 256; i++) push_pkt(4'($urandom_range(0, 15)));
    chk("recv_sat", 32'(recv_cnt), 32'(255));
    step(1, 1, 4'h5, 1, 2'd0, 3'd0);
    chk("midrst_recv", 32'(recv_cnt), 32'(0));
    chk("midrst_occ", 32'(occ), 32'(0));
    chk("midrst_last", 32'(last_in), 32'(0));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) < 2,
           $urandom_range(0, 99) < 60,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 40,
           2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)));
    end
    step(0, 0, 4'h0, 0, 2'd0, 3'd0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(expq.size() + rdq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
